// File: rtl/prach_hb4_pack.sv
// prach_hb4_pack
//   Polyphase packer in front of the half-band decimator. A TDM stream carries
//   each channel's samples in order (phase 0, phase 1, ...). The phase-0 sample
//   is held per channel; the phase-1 sample releases a pair:
//   dp2 = held phase-0 sample (FIR path), dp1 = phase-1 sample (centre tap).
//   Input to output latency is fixed at two cycles.
//
// Ports
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   din_dq    in   [15:0] input sample
//   din_dv    in   din_dq / din_chn valid
//   din_chn   in   [7:0] channel index of din_dq
//   sync_in   in   frame sync; restarts phase tracking in the same cycle
//   dout_dp1  out  [15:0] phase-1 sample of the pair
//   dout_dp2  out  [15:0] phase-0 sample of the pair
//   dout_dv   out  single-cycle pair valid
//   dout_chn  out  [7:0] channel of the pair
//   sync_out  out  sync_in delayed by LATENCY cycles
//   err_chn   out  sticky out-of-range channel flag, cleared by sync_in

module prach_hb4_pack #(
    parameter int unsigned NUM_CHANNEL      = 128,
    parameter int unsigned NUM_CHANNEL_USED = 48,
    parameter int unsigned LATENCY          = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din_dq,
    input  logic        din_dv,
    input  logic [7:0]  din_chn,
    input  logic        sync_in,
    output logic [15:0] dout_dp1,
    output logic [15:0] dout_dp2,
    output logic        dout_dv,
    output logic [7:0]  dout_chn,
    output logic        sync_out,
    output logic        err_chn
);

    localparam int unsigned IdxW = $clog2(NUM_CHANNEL_USED);

    logic [NUM_CHANNEL_USED-1:0] r_phase;
    logic [NUM_CHANNEL_USED-1:0] w_phase_d;
    logic [15:0]                 r_mem [NUM_CHANNEL_USED];

    logic            w_in_range;
    logic            w_accept;
    logic            w_cur_phase;
    logic            w_pair;
    logic            w_err_d;
    logic [IdxW-1:0] w_idx;

    // Stage 1: pair formed from the input cycle
    logic        r_s1_vld;
    logic [15:0] r_s1_dp1;
    logic [15:0] r_s1_dp2;
    logic [7:0]  r_s1_chn;

    // Stage 2: output registers
    logic        r_dout_vld;
    logic [15:0] r_dout_dp1;
    logic [15:0] r_dout_dp2;
    logic [7:0]  r_dout_chn;
    logic        r_err;

    logic [LATENCY-1:0] r_sync_dly;

    assign w_in_range = (32'(din_chn) < NUM_CHANNEL_USED) && (32'(din_chn) < NUM_CHANNEL);
    assign w_idx      = din_chn[IdxW-1:0];
    assign w_accept   = din_dv & w_in_range;
    // A sample presented with sync_in counts as phase 0 of its channel.
    assign w_cur_phase = sync_in ? 1'b0 : r_phase[w_idx];
    assign w_pair      = w_accept & w_cur_phase;

    always_comb begin
        w_phase_d = r_phase;
        if (sync_in) begin
            w_phase_d = '0;
        end
        if (w_accept) begin
            w_phase_d[w_idx] = ~w_cur_phase;
        end
    end

    // Setting on a rejected sample takes priority over the sync clear.
    always_comb begin
        w_err_d = r_err;
        if (sync_in) begin
            w_err_d = 1'b0;
        end
        if (din_dv && !w_in_range) begin
            w_err_d = 1'b1;
        end
    end

    // Hold memory is not reset; phase bits guard against reading stale entries.
    always_ff @(posedge clk) begin
        if (w_accept && !w_cur_phase) begin
            r_mem[w_idx] <= din_dq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_err   <= 1'b0;
        end else begin
            r_phase <= w_phase_d;
            r_err   <= w_err_d;
        end
    end

    // The memory read is combinational off a register array, so a phase-0
    // write at the previous edge is already visible: back-to-back phase-0 /
    // phase-1 samples of one channel pair with the fresh value, never stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_dp1 <= '0;
            r_s1_dp2 <= '0;
            r_s1_chn <= '0;
        end else begin
            r_s1_vld <= w_pair;
            if (w_pair) begin
                r_s1_dp1 <= din_dq;
                r_s1_dp2 <= r_mem[w_idx];
                r_s1_chn <= din_chn;
            end
        end
    end

    // Output data holds its last value when no pair is emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout_vld <= 1'b0;
            r_dout_dp1 <= '0;
            r_dout_dp2 <= '0;
            r_dout_chn <= '0;
        end else begin
            r_dout_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_dout_dp1 <= r_s1_dp1;
                r_dout_dp2 <= r_s1_dp2;
                r_dout_chn <= r_s1_chn;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_dly <= '0;
        end else begin
            r_sync_dly <= {r_sync_dly[LATENCY-2:0], sync_in};
        end
    end

    assign dout_dv  = r_dout_vld;
    assign dout_dp1 = r_dout_dp1;
    assign dout_dp2 = r_dout_dp2;
    assign dout_chn = r_dout_chn;
    assign sync_out = r_sync_dly[LATENCY-1];
    assign err_chn  = r_err;

endmodule

// File: tb/tb_prach_hb4_pack.sv
// Bench for prach_hb4_pack: directed scenarios plus randomized traffic,
// checked every cycle against a per-channel behavioural model.

module tb_prach_hb4_pack;

    logic        clk;
    logic        rst_n;
    logic [15:0] din_dq;
    logic        din_dv;
    logic [7:0]  din_chn;
    logic        sync_in;
    logic [15:0] dout_dp1;
    logic [15:0] dout_dp2;
    logic        dout_dv;
    logic [7:0]  dout_chn;
    logic        sync_out;
    logic        err_chn;

    prach_hb4_pack dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_dq   (din_dq),
        .din_dv   (din_dv),
        .din_chn  (din_chn),
        .sync_in  (sync_in),
        .dout_dp1 (dout_dp1),
        .dout_dp2 (dout_dp2),
        .dout_dv  (dout_dv),
        .dout_chn (dout_chn),
        .sync_out (sync_out),
        .err_chn  (err_chn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_pairs = 0;

    // Reference model state
    bit          m_phase [48];
    logic [15:0] m_mem   [48];
    logic        m_err;
    // Pair expected on the outputs at the next check, and held output values
    logic        e_vld;
    logic [15:0] e_dp1, e_dp2;
    logic [7:0]  e_chn;
    logic        e_sync;
    logic [15:0] h_dp1, h_dp2;
    logic [7:0]  h_chn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 48; i++) m_phase[i] = 1'b0;
        m_err  = 1'b0;
        e_vld  = 1'b0;
        e_dp1  = '0;
        e_dp2  = '0;
        e_chn  = '0;
        e_sync = 1'b0;
        h_dp1  = '0;
        h_dp2  = '0;
        h_chn  = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dv"},  32'(dout_dv),  32'd0);
        chk({tag, "_dp1"}, 32'(dout_dp1), 32'd0);
        chk({tag, "_dp2"}, 32'(dout_dp2), 32'd0);
        chk({tag, "_chn"}, 32'(dout_chn), 32'd0);
        chk({tag, "_sync"}, 32'(sync_out), 32'd0);
        chk({tag, "_err"}, 32'(err_chn),  32'd0);
    endtask

    // One clock cycle: drive inputs at the falling edge, update the model,
    // then check outputs at the next falling edge.
    task automatic cyc(input logic dv, input logic [7:0] ch, input logic [15:0] dq,
                       input logic sy);
        logic        n_vld;
        logic [15:0] n_dp1, n_dp2;
        int          c;
        din_dv  = dv;
        din_chn = ch;
        din_dq  = dq;
        sync_in = sy;
        n_vld = 1'b0;
        n_dp1 = '0;
        n_dp2 = '0;
        c = int'(ch);
        if (sy) begin
            for (int i = 0; i < 48; i++) m_phase[i] = 1'b0;
            m_err = 1'b0;
        end
        if (dv) begin
            if (c < 48) begin
                if (!m_phase[c]) begin
                    m_mem[c]   = dq;
                    m_phase[c] = 1'b1;
                end else begin
                    m_phase[c] = 1'b0;
                    n_vld = 1'b1;
                    n_dp1 = dq;
                    n_dp2 = m_mem[c];
                end
            end else begin
                m_err = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("dout_dv", 32'(dout_dv), 32'(e_vld));
        if (e_vld) begin
            h_dp1 = e_dp1;
            h_dp2 = e_dp2;
            h_chn = e_chn;
        end
        chk("dout_dp1", 32'(dout_dp1), 32'(h_dp1));
        chk("dout_dp2", 32'(dout_dp2), 32'(h_dp2));
        chk("dout_chn", 32'(dout_chn), 32'(h_chn));
        chk("sync_out", 32'(sync_out), 32'(e_sync));
        chk("err_chn",  32'(err_chn),  32'(m_err));
        if (dout_dv === 1'b1) n_pairs++;
        e_vld  = n_vld;
        e_dp1  = n_dp1;
        e_dp2  = n_dp2;
        e_chn  = ch;
        e_sync = sy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 16'd0, 1'b0);
    endtask

    initial begin
        int p0;
        int samples;
        logic        rdv, rsy;
        logic [7:0]  rch;
        logic [15:0] rdq;

        rst_n   = 1'b0;
        din_dv  = 1'b0;
        din_chn = '0;
        din_dq  = '0;
        sync_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // 1: all 48 channels, phase 0 then phase 1
        cyc(1'b0, 8'd0, 16'd0, 1'b1);
        p0 = n_pairs;
        for (int ch = 0; ch < 48; ch++) cyc(1'b1, 8'(ch), 16'(16'h1000 + ch), 1'b0);
        for (int ch = 0; ch < 48; ch++) cyc(1'b1, 8'(ch), 16'(16'h2000 + ch), 1'b0);
        idle(3);
        chk("t1_pair_count", 32'(n_pairs - p0), 32'd48);

        // 2: back-to-back same channel (forwarding)
        cyc(1'b1, 8'd5, 16'h0AAA, 1'b0);
        cyc(1'b1, 8'd5, 16'h0BBB, 1'b0);
        idle(1);
        chk("t2_dp2", 32'(dout_dp2), 32'h0AAA);
        chk("t2_dp1", 32'(dout_dp1), 32'h0BBB);

        // 3: sync discards a held phase-0 sample
        p0 = n_pairs;
        cyc(1'b1, 8'd7, 16'h1111, 1'b0);
        cyc(1'b0, 8'd0, 16'd0, 1'b1);
        cyc(1'b1, 8'd7, 16'h2222, 1'b0);
        cyc(1'b1, 8'd7, 16'h3333, 1'b0);
        idle(1);
        chk("t3_dp2", 32'(dout_dp2), 32'h2222);
        chk("t3_dp1", 32'(dout_dp1), 32'h3333);
        idle(2);
        chk("t3_pair_count", 32'(n_pairs - p0), 32'd1);

        // 4: out-of-range channels
        p0 = n_pairs;
        cyc(1'b1, 8'd0, 16'h0C00, 1'b0);
        cyc(1'b1, 8'd48, 16'h9999, 1'b0);
        cyc(1'b1, 8'd127, 16'h8888, 1'b0);
        cyc(1'b1, 8'd0, 16'h0C01, 1'b0);
        idle(2);
        chk("t4_err_set", 32'(err_chn), 32'd1);
        chk("t4_pair_count", 32'(n_pairs - p0), 32'd1);
        cyc(1'b0, 8'd0, 16'd0, 1'b1);
        chk("t4_err_clr", 32'(err_chn), 32'd0);
        cyc(1'b1, 8'd100, 16'h5555, 1'b1);
        chk("t4_err_set_wins", 32'(err_chn), 32'd1);
        cyc(1'b0, 8'd0, 16'd0, 1'b1);
        idle(2);

        // 5: randomized traffic, 30% duty
        samples = 0;
        while (samples < 2000) begin
            rdv = ($urandom_range(0, 99) < 30);
            rsy = ($urandom_range(0, 299) == 0);
            rdq = 16'($urandom);
            if ($urandom_range(0, 49) == 0) rch = 8'($urandom_range(48, 255));
            else rch = 8'($urandom_range(0, 7));
            if (rdv) samples++;
            cyc(rdv, rch, rdq, rsy);
        end
        idle(3);

        // 6: asynchronous reset mid-stream with ch3 at phase 1
        cyc(1'b0, 8'd0, 16'd0, 1'b1);
        cyc(1'b1, 8'd1, 16'h1234, 1'b0);
        cyc(1'b1, 8'd1, 16'h5678, 1'b0);
        cyc(1'b1, 8'd3, 16'h0001, 1'b0);
        chk("t6_pre_dp1", 32'(dout_dp1), 32'h5678);
        #1 rst_n = 1'b0;
        din_dv = 1'b0;
        #1 chk_all_zero("t6_async");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        p0 = n_pairs;
        cyc(1'b1, 8'd3, 16'h7FFF, 1'b0);
        idle(3);
        chk("t6_no_pair", 32'(n_pairs - p0), 32'd0);
        cyc(1'b1, 8'd3, 16'h0123, 1'b0);
        idle(1);
        chk("t6_dp2", 32'(dout_dp2), 32'h7FFF);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
